// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multicycle lvm-16 core, FETCH/EXEC/MEM sequencing over req/ack memory ports.
// Optional LVM_HALT_EN: JMP with [7:0]==8'hFF halts the core until reset.
module cpu_multicycle #(
    parameter int                WIDTH    = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [WIDTH-1:0]  dmem_wdata,
    input  logic              dmem_ack,
    input  logic [WIDTH-1:0]  dmem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [WIDTH-1:0]  instret,
    output logic              halted
);
    // state   | meaning
    // S_FETCH | imem_req held until imem_ack, instruction latched
    // S_EXEC  | ALU/JMP retire; LOAD/STORE capture address and store data
    // S_MEM   | dmem_req held until dmem_ack, load writeback
    // S_HALT  | idle with no requests until reset
    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

    localparam logic [1:0] OP_JMP   = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_ALU   = 2'b11;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, daddr_q, daddr_d;
    logic [WIDTH-1:0]  instret_q, instret_d, wdata_q, wdata_d;
    logic [15:0]       ir_q, ir_d;
    logic [WIDTH-1:0]  gpr_q [4];
    logic [WIDTH-1:0]  gpr_d [4];
    logic              imem_req_q, imem_req_d, dmem_req_q, dmem_req_d, we_q, we_d;

    logic [1:0]        op, rd, rs1_idx, rs2_idx;
    logic [WIDTH-1:0]  rs1_val, rs2_val, alu_x, alu_y, alu_f, alu_out;
    logic [ADDR_W-1:0] pc_inc;
    logic              jmp_taken;
    logic              unused_ir;

    assign op        = ir_q[15:14];
    assign rd        = ir_q[13:12];
    assign rs1_idx   = ir_q[11:10];
    assign rs2_idx   = ir_q[9:8];
    assign rs1_val   = (rs1_idx == 2'd0) ? '0 : gpr_q[rs1_idx];
    assign rs2_val   = (rs2_idx == 2'd0) ? '0 : gpr_q[rs2_idx];
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign unused_ir = ^ir_q[1:0];

    always_comb begin
        alu_x = ir_q[7] ? '0 : rs1_val;
        if (ir_q[6]) alu_x = ~alu_x;
        alu_y = ir_q[5] ? '0 : rs2_val;
        if (ir_q[4]) alu_y = ~alu_y;
        alu_f   = ir_q[3] ? (alu_x + alu_y) : (alu_x & alu_y);
        alu_out = ir_q[2] ? ~alu_f : alu_f;
    end

    always_comb begin
        case (rd)
            2'b00:   jmp_taken = 1'b1;
            2'b01:   jmp_taken = (rs2_val == '0);
            2'b10:   jmp_taken = rs2_val[WIDTH-1];
            default: jmp_taken = (rs2_val != '0) && !rs2_val[WIDTH-1];
        endcase
    end

`ifdef LVM_HALT_EN
    logic halted_q, halted_d;
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        gpr_d      = gpr_q;
        instret_d  = instret_q;
        daddr_d    = daddr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        imem_req_d = imem_req_q;
        dmem_req_d = dmem_req_q;
`ifdef LVM_HALT_EN
        halted_d   = halted_q;
`endif
        case (state_q)
            S_FETCH: begin
                // Request is registered, so an ack is only honoured once the request is visible.
                imem_req_d = 1'b1;
                if (imem_req_q && imem_ack) begin
                    ir_d       = imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_ALU: begin
                        gpr_d[rd]  = alu_out;
                        pc_d       = pc_inc;
                        instret_d  = instret_q + WIDTH'(1);
                        imem_req_d = 1'b1;
                        state_d    = S_FETCH;
                    end
                    OP_JMP: begin
`ifdef LVM_HALT_EN
                        if (ir_q[7:0] == 8'hFF) begin
                            instret_d = instret_q + WIDTH'(1);
                            halted_d  = 1'b1;
                            state_d   = S_HALT;
                        end else
`endif
                        begin
                            pc_d       = jmp_taken ? rs1_val[ADDR_W-1:0] : pc_inc;
                            instret_d  = instret_q + WIDTH'(1);
                            imem_req_d = 1'b1;
                            state_d    = S_FETCH;
                        end
                    end
                    default: begin
                        daddr_d    = rs1_val[ADDR_W-1:0];
                        wdata_d    = rs2_val;
                        we_d       = (op == OP_STORE);
                        dmem_req_d = 1'b1;
                        state_d    = S_MEM;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_req_q && dmem_ack) begin
                    if (!we_q) gpr_d[rd] = dmem_rdata;
                    we_d       = 1'b0;
                    dmem_req_d = 1'b0;
                    pc_d       = pc_inc;
                    instret_d  = instret_q + WIDTH'(1);
                    imem_req_d = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            default: ;
        endcase
        gpr_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            gpr_q      <= '{default: '0};
            instret_q  <= '0;
            daddr_q    <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
`ifdef LVM_HALT_EN
            halted_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            gpr_q      <= gpr_d;
            instret_q  <= instret_d;
            daddr_q    <= daddr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            imem_req_q <= imem_req_d;
            dmem_req_q <= dmem_req_d;
`ifdef LVM_HALT_EN
            halted_q   <= halted_d;
`endif
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = daddr_q;
    assign dmem_wdata = wdata_q;
    assign pc         = pc_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed program for cpu_multicycle with fetch/data scoreboards and an ISA model.
// Build with LVM_HALT_EN defined to exercise the HALT variant.
module tb_cpu_multicycle;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [15:0] pc, instret;
    logic        halted;

    always #5 clk = ~clk;

    cpu_multicycle dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .pc(pc), .instret(instret), .halted(halted)
    );

    typedef struct { logic [15:0] pc; logic [15:0] ret; } fexp_t;
    typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; logic [1:0] rd; } mexp_t;

    fexp_t       fq[$];
    mexp_t       mq[$];
    logic [15:0] m_r [4];
    logic [15:0] m_pc, m_ret;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          lat_i   = -1;
    int          lat_d   = -1;
    bit          spur    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mr(input logic [1:0] idx);
        return (idx == 2'd0) ? 16'h0 : m_r[idx];
    endfunction

    task automatic push_fetch();
        fexp_t fe;
        fe.pc  = m_pc;
        fe.ret = m_ret;
        fq.push_back(fe);
    endtask

    task automatic model_exec(input logic [15:0] ins);
        logic [15:0] a, b, x, y, f;
        logic        t;
        mexp_t       me;
        a = mr(ins[11:10]);
        b = mr(ins[9:8]);
        case (ins[15:14])
            2'b11: begin
                x = ins[7] ? 16'h0 : a;
                if (ins[6]) x = ~x;
                y = ins[5] ? 16'h0 : b;
                if (ins[4]) y = ~y;
                f = ins[3] ? x + y : x & y;
                if (ins[2]) f = ~f;
                if (ins[13:12] != 2'd0) m_r[ins[13:12]] = f;
                m_pc++;
                m_ret++;
                push_fetch();
                lat_i = 1;
            end
            2'b00: begin
`ifdef LVM_HALT_EN
                if (ins[7:0] == 8'hFF) begin
                    m_ret++;
                    return;
                end
`endif
                case (ins[13:12])
                    2'd0:    t = 1'b1;
                    2'd1:    t = (b == 16'h0);
                    2'd2:    t = b[15];
                    default: t = (b != 16'h0) && !b[15];
                endcase
                m_pc = t ? a : m_pc + 16'd1;
                m_ret++;
                push_fetch();
                lat_i = 1;
            end
            default: begin
                me.we    = (ins[15:14] == 2'b10);
                me.addr  = a;
                me.wdata = b;
                me.rd    = ins[13:12];
                mq.push_back(me);
                lat_d = 1;
            end
        endcase
    endtask

    task automatic do_fetch(input logic [15:0] ins, input int wt);
        int    n;
        fexp_t e;
        n = 0;
        e.pc = 16'h0;
        e.ret = 16'h0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("imem_req", imem_req, 1);
        if (lat_i >= 0) chk("fetch_latency", n, lat_i);
        if (fq.size() != 0) e = fq.pop_front();
        chk("imem_addr", imem_addr, e.pc);
        chk("pc", pc, e.pc);
        chk("instret", instret, e.ret);
        chk("dmem_req_idle", dmem_req, 0);
        if (spur) dmem_ack = 1'b1;
        repeat (wt) begin
            @(negedge clk);
            chk("imem_req_hold", imem_req, 1);
            chk("imem_addr_hold", imem_addr, e.pc);
        end
        dmem_ack   = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = ins;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'h0;
        model_exec(ins);
    endtask

    task automatic do_mem(input logic [15:0] rdata, input int wt);
        int    n;
        mexp_t e;
        n = 0;
        e.we = 1'b0; e.addr = 16'h0; e.wdata = 16'h0; e.rd = 2'd0;
        while (dmem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("dmem_req", dmem_req, 1);
        if (lat_d >= 0) chk("mem_latency", n, lat_d);
        if (mq.size() != 0) e = mq.pop_front();
        chk("dmem_we", dmem_we, e.we);
        chk("dmem_addr", dmem_addr, e.addr);
        chk("dmem_wdata", dmem_wdata, e.wdata);
        chk("imem_req_idle", imem_req, 0);
        if (spur) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'hFFFF;
        end
        repeat (wt) begin
            @(negedge clk);
            chk("dmem_req_hold", dmem_req, 1);
            chk("dmem_we_hold", dmem_we, e.we);
            chk("dmem_addr_hold", dmem_addr, e.addr);
            chk("dmem_wdata_hold", dmem_wdata, e.wdata);
            chk("pc_before_ack", pc, m_pc);
        end
        imem_ack   = 1'b0;
        imem_rdata = 16'h0;
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0;
        if (!e.we && e.rd != 2'd0) m_r[e.rd] = rdata;
        m_pc++;
        m_ret++;
        push_fetch();
        lat_i = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 16'h0;
        m_pc  = 16'h0;
        m_ret = 16'h0;
        fq.delete();
        mq.delete();
        push_fetch();
        lat_i = -1;
        lat_d = -1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_imem_req", imem_req, 0);
        chk("rst_imem_addr", imem_addr, 16'h0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_dmem_addr", dmem_addr, 16'h0);
        chk("rst_dmem_wdata", dmem_wdata, 16'h0);
        chk("rst_pc", pc, 16'h0);
        chk("rst_instret", instret, 16'h0);
        chk("rst_halted", halted, 0);
    endtask

    initial begin
        int n;
        reset      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0;
        dmem_ack   = 1'b0;
        dmem_rdata = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        reset = 1'b1;

        // ALU sequence, then load/store traffic with wait states
        do_fetch(16'hD0C8, 0);
        do_fetch(16'hD434, 0);
        do_fetch(16'hD0FC, 0);
        do_fetch(16'h7400, 0); do_mem(16'hBEEF, 3);
        do_fetch(16'h5400, 1); do_mem(16'h0010, 0);
        do_fetch(16'h6400, 0); do_mem(16'h1234, 3);
        do_fetch(16'h8700, 0); do_mem(16'hDEAD, 2);
        do_fetch(16'h8200, 0); do_mem(16'hDEAD, 0);
        do_fetch(16'hE708, 0);
        do_fetch(16'h8A00, 0); do_mem(16'h0000, 0);
        do_fetch(16'hC0FC, 0);
        do_fetch(16'h8000, 0); do_mem(16'h0000, 0);

        // jumps on every condition, then pc wrap from 0xFFFF
        do_fetch(16'h1400, 0);
        do_fetch(16'h1D00, 0);
        do_fetch(16'h2B00, 0);
        do_fetch(16'h3700, 0);
        do_fetch(16'h3100, 0);
        do_fetch(16'h0800, 0);
        do_fetch(16'hD0C8, 0);
        do_fetch(16'h0400, 0);
        do_fetch(16'h1100, 0);

        // stray acks on the idle port
        spur = 1'b1;
        do_fetch(16'hD0FC, 2);
        spur = 1'b0;
        do_fetch(16'h7400, 0);
        spur = 1'b1;
        do_mem(16'h5555, 2);
        spur = 1'b0;

        // asynchronous reset while a fetch is outstanding
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("imem_req_before_reset", imem_req, 1);
        chk("pc_before_reset", pc, m_pc);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_outputs();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        do_fetch(16'hD0FC, 0);
        do_fetch(16'h8300, 0); do_mem(16'h0000, 0);

        do_fetch(16'h04FF, 0);
`ifdef LVM_HALT_EN
        repeat (20) begin
            @(negedge clk);
            chk("halt_no_imem_req", imem_req, 0);
            chk("halt_no_dmem_req", dmem_req, 0);
        end
        chk("halted", halted, 1);
        chk("halt_pc", pc, m_pc);
        chk("halt_instret", instret, m_ret);
`else
        do_fetch(16'hC000, 0);
        chk("halted_tied", halted, 0);
        do_fetch(16'hC000, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
